// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the processor data bus.
// Accepts BUS_LOAD / BUS_STORE requests, services them against an internal
// word array after LATENCY cycles, and returns data plus an error flag.
// Optional sub-word (byte/half) access is enabled by defining DMEM_SUBWORD_EN.
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2mem_data,
`ifdef DMEM_SUBWORD_EN
  input  logic [2:0]  proc2Dmem_size,
`endif
  output logic [31:0] mem2proc_data,
  output logic        mem2proc_valid,
  output logic        mem2proc_error,
  output logic        mem2proc_ready
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_next;
  logic [3:0]         count, count_next;
  logic               accept;
  logic               req_load, req_store, req_err;
  logic [31:0]        offset;
  logic               below_base, out_of_range, misaligned, bad_size;
  logic               unused_offset_bits;

  logic               is_store_q, err_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        data_q;
`ifdef DMEM_SUBWORD_EN
  logic [1:0]         lane_q;
  logic [2:0]         size_q;
  logic [31:0]        rd_shift;
`endif

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_word, load_value, wdata;
  logic [3:0]         wmask;

  // Request decode and address checking on the live bus inputs
  always_comb begin
    req_load     = (proc2Dmem_command == 2'b01);
    req_store    = (proc2Dmem_command == 2'b10);
    offset       = proc2Dmem_addr - BASE_ADDR;
    below_base   = (proc2Dmem_addr < BASE_ADDR);
    out_of_range = ({2'b00, offset[31:2]} >= 32'(DEPTH));
    unused_offset_bits = ^offset[1:0];
    bad_size     = 1'b0;
`ifdef DMEM_SUBWORD_EN
    case (proc2Dmem_size)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = proc2Dmem_addr[0];
      3'b010:         misaligned = |proc2Dmem_addr[1:0];
      default: begin
        misaligned = 1'b0;
        bad_size   = 1'b1;
      end
    endcase
`else
    misaligned = |proc2Dmem_addr[1:0];
`endif
    req_err = below_base | out_of_range | misaligned | bad_size;
    accept  = mem2proc_ready & (req_load | req_store);
  end

  // State and latency counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic: accept from IDLE or RESP, count down through WAIT
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            count_next = 4'd0;
          end else begin
            state_next = WAIT;
            count_next = LAT_M1;
          end
        end else if (state == RESP) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (count <= 4'd1) begin
          state_next = RESP;
          count_next = 4'd0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the accepted request; the FSM decides whether it is ever serviced
  always_ff @(posedge clk) begin
    if (accept) begin
      is_store_q <= req_store;
      err_q      <= req_err;
      idx_q      <= offset[IDX_W+1:2];
      data_q     <= proc2mem_data;
`ifdef DMEM_SUBWORD_EN
      lane_q     <= proc2Dmem_addr[1:0];
      size_q     <= proc2Dmem_size;
`endif
    end
  end

  // Read path and store lane merge for the request being answered
  always_comb begin
    rd_word = mem[idx_q];
`ifdef DMEM_SUBWORD_EN
    rd_shift = rd_word >> {lane_q, 3'b000};
    case (size_q)
      3'b000:  load_value = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_value = {24'h0, rd_shift[7:0]};
      3'b001:  load_value = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_value = {16'h0, rd_shift[15:0]};
      default: load_value = rd_word;
    endcase
    wdata = data_q << {lane_q, 3'b000};
    case (size_q[1:0])
      2'b00:   wmask = 4'b0001 << lane_q;
      2'b01:   wmask = 4'b0011 << lane_q;
      default: wmask = 4'b1111;
    endcase
`else
    load_value = rd_word;
    wdata      = data_q;
    wmask      = 4'b1111;
`endif
  end

  // Store commits at the edge closing RESP, unless erroneous or reset
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && is_store_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Bus outputs decoded from the current state
  always_comb begin
    mem2proc_ready = (state != WAIT);
    mem2proc_valid = (state == RESP);
    mem2proc_error = (state == RESP) & err_q;
    mem2proc_data  = 32'h0;
    if (state == RESP && !is_store_q && !err_q) mem2proc_data = load_value;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (LATENCY=2 at base 0, and
// LATENCY=1 with a small array at a non-zero base) checked by scoreboards.
// Sub-word cases run only when DMEM_SUBWORD_EN is defined.
module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [1:0]  cmd   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  size  [2];
  logic [31:0] rdata [2];
  logic        valid [2];
  logic        err   [2];
  logic        ready [2];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned t_a, t_b, t_x;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT0), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst[0]),
    .proc2Dmem_command(cmd[0]), .proc2Dmem_addr(addr[0]), .proc2mem_data(wdata[0]),
`ifdef DMEM_SUBWORD_EN
    .proc2Dmem_size(size[0]),
`endif
    .mem2proc_data(rdata[0]), .mem2proc_valid(valid[0]),
    .mem2proc_error(err[0]), .mem2proc_ready(ready[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(LAT1), .BASE_ADDR(32'h0000_0200)) dut1 (
    .clk(clk), .rst(rst[1]),
    .proc2Dmem_command(cmd[1]), .proc2Dmem_addr(addr[1]), .proc2mem_data(wdata[1]),
`ifdef DMEM_SUBWORD_EN
    .proc2Dmem_size(size[1]),
`endif
    .mem2proc_data(rdata[1]), .mem2proc_valid(valid[1]),
    .mem2proc_error(err[1]), .mem2proc_ready(ready[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a request at a falling edge, hold it until accepted, record the
  // expected response and the cycle it must appear in.
  task automatic applyStimulus(input int sel, input logic [1:0] c, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] sz, input bit expect_resp,
                               input logic [31:0] exp_data, input logic exp_err,
                               output int unsigned acc);
    exp_t e;
    cmd[sel]   = c;
    addr[sel]  = a;
    wdata[sel] = d;
    size[sel]  = sz;
    for (int k = 0; k < 40 && !ready[sel]; k++) @(negedge clk);
    if (!ready[sel]) checkOutput("ready_timeout", {31'h0, ready[sel]}, 32'h1);
    acc = cyc;
    if (expect_resp) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.cyc  = cyc + ((sel == 0) ? LAT0 : LAT1);
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    @(negedge clk);
    cmd[sel] = BUS_NONE;
  endtask

  task automatic doStore(input int sel, input logic [31:0] a, input logic [31:0] d, input logic ee);
    int unsigned t;
    applyStimulus(sel, BUS_STORE, a, d, 3'b010, 1'b1, 32'h0, ee, t);
  endtask

  task automatic doLoad(input int sel, input logic [31:0] a, input logic [31:0] ed, input logic ee);
    int unsigned t;
    applyStimulus(sel, BUS_LOAD, a, 32'h0, 3'b010, 1'b1, ed, ee, t);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard for the LATENCY=2 instance
  always @(negedge clk) begin
    if (valid[0]) begin
      if (q0.size() == 0) begin
        checkOutput("dut0_spurious_valid", 32'h1, 32'h0);
      end else begin
        e0 = q0.pop_front();
        checkOutput("dut0_data", rdata[0], e0.data);
        checkOutput("dut0_error", {31'h0, err[0]}, {31'h0, e0.err});
        checkOutput("dut0_resp_cycle", cyc, e0.cyc);
      end
    end else if (err[0]) begin
      checkOutput("dut0_error_without_valid", 32'h1, 32'h0);
    end
  end

  // Scoreboard for the LATENCY=1 instance
  always @(negedge clk) begin
    if (valid[1]) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_spurious_valid", 32'h1, 32'h0);
      end else begin
        e1 = q1.pop_front();
        checkOutput("dut1_data", rdata[1], e1.data);
        checkOutput("dut1_error", {31'h0, err[1]}, {31'h0, e1.err});
        checkOutput("dut1_resp_cycle", cyc, e1.cyc);
      end
    end else if (err[1]) begin
      checkOutput("dut1_error_without_valid", 32'h1, 32'h0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s]   = 1'b1;
      cmd[s]   = BUS_NONE;
      addr[s]  = 32'h0;
      wdata[s] = 32'h0;
      size[s]  = 3'b010;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'h0, ready[0]}, 32'h1);
    checkOutput("reset_valid", {31'h0, valid[0]}, 32'h0);
    checkOutput("reset_error", {31'h0, err[0]}, 32'h0);
    checkOutput("reset_data", rdata[0], 32'h0);
    checkOutput("reset_ready_dut1", {31'h0, ready[1]}, 32'h1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    idle(1);

    $display("[TB] store/load with LATENCY=2");
    applyStimulus(0, BUS_STORE, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 32'h0, 1'b0, t_a);
    checkOutput("store_ready_in_wait", {31'h0, ready[0]}, 32'h0);
    idle(1);
    checkOutput("store_ready_in_resp", {31'h0, ready[0]}, 32'h1);
    idle(1);
    doLoad(0, 32'h10, 32'hDEADBEEF, 1'b0);
    idle(3);

    $display("[TB] back-to-back store then load");
    applyStimulus(0, BUS_STORE, 32'h20, 32'h1234, 3'b010, 1'b1, 32'h0, 1'b0, t_a);
    applyStimulus(0, BUS_LOAD, 32'h20, 32'h0, 3'b010, 1'b1, 32'h00001234, 1'b0, t_b);
    checkOutput("load_accepted_in_store_resp", t_b - t_a, LAT0);
    idle(4);

    $display("[TB] error responses");
    doStore(0, 32'h0, 32'h11111111, 1'b0);
    doLoad(0, 32'h13, 32'h0, 1'b1);
    doStore(0, 32'h1000, 32'h99999999, 1'b1);
    doLoad(0, 32'h0, 32'h11111111, 1'b0);
    doStore(1, 32'h2FC, 32'hA5A5A5A5, 1'b0);
    doLoad(1, 32'h2FC, 32'hA5A5A5A5, 1'b0);
    doLoad(1, 32'h300, 32'h0, 1'b1);
    doLoad(1, 32'h1FC, 32'h0, 1'b1);
    idle(4);

    $display("[TB] LATENCY=1 sweep");
    for (int i = 0; i < 8; i++) begin
      checkOutput("lat1_ready", {31'h0, ready[1]}, 32'h1);
      if (i % 2 == 0) doStore(1, 32'h240, 32'h1000 + i, 1'b0);
      else            doLoad(1, 32'h240, 32'h1000 + i - 1, 1'b0);
    end
    idle(4);

    $display("[TB] reset during an outstanding store");
    doStore(0, 32'h30, 32'h5555AAAA, 1'b0);
    idle(3);
    applyStimulus(0, BUS_STORE, 32'h30, 32'h0000CAFE, 3'b010, 1'b0, 32'h0, 1'b0, t_x);
    rst[0] = 1'b1;
    idle(1);
    rst[0] = 1'b0;
    checkOutput("rst_ready", {31'h0, ready[0]}, 32'h1);
    checkOutput("rst_no_valid", {31'h0, valid[0]}, 32'h0);
    idle(4);
    doLoad(0, 32'h30, 32'h5555AAAA, 1'b0);
    idle(4);

`ifdef DMEM_SUBWORD_EN
    $display("[TB] sub-word accesses");
    applyStimulus(0, BUS_STORE, 32'h50, 32'h80FF7F01, 3'b010, 1'b1, 32'h0, 1'b0, t_x);
    applyStimulus(0, BUS_LOAD, 32'h53, 32'h0, 3'b000, 1'b1, 32'hFFFFFF80, 1'b0, t_x);
    applyStimulus(0, BUS_LOAD, 32'h53, 32'h0, 3'b100, 1'b1, 32'h00000080, 1'b0, t_x);
    applyStimulus(0, BUS_STORE, 32'h52, 32'h0000AAAA, 3'b001, 1'b1, 32'h0, 1'b0, t_x);
    applyStimulus(0, BUS_LOAD, 32'h50, 32'h0, 3'b010, 1'b1, 32'hAAAA7F01, 1'b0, t_x);
    applyStimulus(0, BUS_LOAD, 32'h52, 32'h0, 3'b101, 1'b1, 32'h0000AAAA, 1'b0, t_x);
    applyStimulus(0, BUS_LOAD, 32'h51, 32'h0, 3'b001, 1'b1, 32'h0, 1'b1, t_x);
    applyStimulus(0, BUS_LOAD, 32'h50, 32'h0, 3'b011, 1'b1, 32'h0, 1'b1, t_x);
    idle(4);
`endif

    for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    checkOutput("drain_dut0", q0.size(), 32'h0);
    checkOutput("drain_dut1", q1.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
